// File: rtl/wb_uart_tx_feeder_pkg.sv
// Shared constants and types for the Wishbone UART transmit feeder.
package wb_uart_tx_feeder_pkg;

  // Slave register word offsets (decoded on wbs_adr_i[3:2])
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // CTRL bit positions
  localparam int CTRL_FLUSH  = 0;
  localparam int CTRL_IRQ_EN = 1;

  // Downstream 16550 byte offsets
  localparam logic [31:0] UART_THR = 32'd0;
  localparam logic [31:0] UART_LSR = 32'd5;

  // LSR transmit-holding-register-empty bit; LSR sits on byte lane 2
  localparam int LSR_THRE = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_LSR = 2'd1,
    ST_WR_THR = 2'd2
  } mst_state_e;

endpackage

// File: rtl/wb_uart_tx_fifo.sv
// 8-bit synchronous FIFO; a push while full is dropped even if a pop
// happens in the same cycle. Flush clears count and pointers.
module wb_uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next pointers/count; flush wins over everything
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/count state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an empty count makes its contents unreachable
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/wb_uart_tx_feeder.sv
// Wishbone slave byte queue that drains into a 16550 THR by polling LSR.
// Optional: define WB_UART_TX_FEEDER_OVF_ERR_EN to answer DATA writes to a
// full FIFO with wbs_err_o instead of wbs_ack_o.
module wb_uart_tx_feeder
  import wb_uart_tx_feeder_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] UART_BASE  = 32'h0
) (
  input  logic        clk,
  input  logic        rst_sys,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        wbs_rty_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic [31:0] wbm_dat_i,
  output logic        irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          ack_q, ack_d, err_q, err_d, ovf_q, ovf_d;
  logic          irq_en_q, irq_en_d, irq_q, irq_d;
  logic [31:0]   dat_q, dat_d;
  mst_state_e    state_q, state_d;
  logic          cyc_q, cyc_d, pend_q, pend_d;
  logic          acc, push, pop, flush, abort;
  logic [7:0]    head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;

  wb_uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst_sys), .push(push), .pop(pop), .flush(flush),
    .din(wbs_dat_i[7:0]), .dout(head), .count(fifo_count),
    .full(fifo_full), .empty(fifo_empty)
  );

  // A request is taken only when no response is in flight, so a held
  // request is answered every second cycle
  assign acc = wbs_cyc_i & wbs_stb_i & ~ack_q & ~err_q;

  // Slave decode: register side effects and the registered response
  always_comb begin
    ack_d    = 1'b0;
    err_d    = 1'b0;
    dat_d    = '0;
    push     = 1'b0;
    flush    = 1'b0;
    ovf_d    = ovf_q;
    irq_en_d = irq_en_q;
    if (acc) begin
      ack_d = 1'b1;
      case (wbs_adr_i[3:2])
        REG_DATA: begin
          if (wbs_we_i && wbs_sel_i[0]) begin
            if (fifo_full) begin
              ovf_d = 1'b1;
`ifdef WB_UART_TX_FEEDER_OVF_ERR_EN
              ack_d = 1'b0;
              err_d = 1'b1;
`endif
            end else begin
              push = 1'b1;
            end
          end
        end
        REG_STATUS: begin
          if (!wbs_we_i)
            dat_d = {16'h0, 8'(fifo_count), 5'h0, ovf_q, fifo_full, fifo_empty};
        end
        REG_CTRL: begin
          if (wbs_we_i) begin
            if (wbs_sel_i[0]) begin
              flush    = wbs_dat_i[CTRL_FLUSH];
              irq_en_d = wbs_dat_i[CTRL_IRQ_EN];
            end
          end else begin
            dat_d = {30'h0, irq_en_q, 1'b0};
          end
        end
        default: ;
      endcase
    end
    if (flush) ovf_d = 1'b0;
    irq_d = irq_en_q & fifo_empty;
  end

  // A flush while an access is outstanding lets it finish, then aborts
  assign abort = flush | pend_q;

  // Master FSM: poll LSR until THRE, write THR, pop; cyc drops for at
  // least one cycle between accesses
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    pend_d  = pend_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !flush) begin
          state_d = ST_RD_LSR;
          cyc_d   = 1'b1;
        end
      end
      default: begin
        if (cyc_q) begin
          if (wbm_ack_i || wbm_err_i) begin
            cyc_d  = 1'b0;
            pend_d = 1'b0;
            if (abort || wbm_err_i)          state_d = ST_IDLE;
            else if (state_q == ST_WR_THR) begin
              pop     = 1'b1;
              state_d = ST_IDLE;
            end
            else if (wbm_dat_i[16+LSR_THRE]) state_d = ST_WR_THR;
            else                             state_d = ST_RD_LSR;
          end else begin
            pend_d = abort;
          end
        end else if (abort) begin
          state_d = ST_IDLE;
          pend_d  = 1'b0;
        end else begin
          cyc_d = 1'b1;
        end
      end
    endcase
  end

  // All registered state
  always_ff @(posedge clk or posedge rst_sys) begin
    if (rst_sys) begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dat_q    <= '0;
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      state_q  <= ST_IDLE;
      cyc_q    <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      ack_q    <= ack_d;
      err_q    <= err_d;
      dat_q    <= dat_d;
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      pend_q   <= pend_d;
    end
  end

  assign wbs_ack_o = ack_q;
`ifdef WB_UART_TX_FEEDER_OVF_ERR_EN
  assign wbs_err_o = err_q;
`else
  assign wbs_err_o = 1'b0;
`endif
  assign wbs_rty_o = 1'b0;
  assign wbs_dat_o = dat_q;
  assign irq       = irq_q;

  // Master request fields are qualified by cyc so they read 0 when idle
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = cyc_q & (state_q == ST_WR_THR);
  assign wbm_adr_o = !cyc_q ? 32'h0 :
                     (state_q == ST_WR_THR) ? UART_BASE + UART_THR : UART_BASE + UART_LSR;
  assign wbm_sel_o = !cyc_q ? 4'h0 : (state_q == ST_WR_THR) ? 4'b1000 : 4'b0100;
  assign wbm_dat_o = wbm_we_o ? {head, 24'h0} : 32'h0;

  logic unused_sigs;
  assign unused_sigs = &{1'b0, wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:8],
                         wbs_sel_i[3:1], wbm_dat_i[31:22], wbm_dat_i[20:0], err_q};

endmodule

// File: tb/tb_wb_uart_tx_feeder.sv
// Self-checking bench for wb_uart_tx_feeder: register table, directed
// multi-cycle sequences, and randomized rounds against a queue model.
module tb_wb_uart_tx_feeder;
  localparam logic [31:0] UB = 32'h0000_1000;
`ifdef WB_UART_TX_FEEDER_OVF_ERR_EN
  localparam bit OVF_ERR = 1'b1;
`else
  localparam bit OVF_ERR = 1'b0;
`endif
  localparam logic [1:0] W_DATA = 2'd0, W_STAT = 2'd1, W_CTRL = 2'd2, W_RSVD = 2'd3;

  logic        clk = 1'b0, rst_sys;
  logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
  logic [3:0]  wbs_sel_i;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_ack_o, wbs_err_o, wbs_rty_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, irq;
  logic        wbm_ack_i = 1'b0, wbm_err_i = 1'b0;
  logic [31:0] wbm_dat_i = 32'h0;

  wb_uart_tx_feeder #(.FIFO_DEPTH(16), .UART_BASE(UB)) dut (
    .clk(clk), .rst_sys(rst_sys),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_rty_o(wbs_rty_o), .wbs_dat_o(wbs_dat_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_dat_i(wbm_dat_i), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- UART responder model ----------------
  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        err;
  } acc_t;
  acc_t acc_log[$];
  bit   resp_en = 1'b0;
  int   lsr_busy = 0;       // LSR polls answered "busy" before THRE
  int   err_wr_index = -1;  // which served THR write gets wbm_err_i
  int   wr_served = 0, lsr_polls = 0;

  function automatic acc_t mk_acc(input logic we, input logic [31:0] a, input logic [3:0] s,
                                  input logic [31:0] d, input logic e);
    acc_t r;
    r.we = we; r.adr = a; r.sel = s; r.dat = d; r.err = e;
    return r;
  endfunction

  always @(posedge clk) begin
    wbm_ack_i <= 1'b0;
    wbm_err_i <= 1'b0;
    if (resp_en && wbm_cyc_o && wbm_stb_o && !wbm_ack_i && !wbm_err_i) begin
      if (wbm_we_o) begin
        wbm_err_i <= (wr_served == err_wr_index);
        wbm_ack_i <= (wr_served != err_wr_index);
        acc_log.push_back(mk_acc(1'b1, wbm_adr_o, wbm_sel_o, wbm_dat_o, wr_served == err_wr_index));
        wr_served <= wr_served + 1;
        lsr_polls <= 0;
      end else begin
        wbm_ack_i <= 1'b1;
        wbm_dat_i <= (lsr_polls >= lsr_busy) ? 32'h0020_0000 : 32'h0;
        acc_log.push_back(mk_acc(1'b0, wbm_adr_o, wbm_sel_o,
                                 (lsr_polls >= lsr_busy) ? 32'h0020_0000 : 32'h0, 1'b0));
        lsr_polls <= (lsr_polls >= lsr_busy) ? 0 : lsr_polls + 1;
      end
    end
  end

  // Bus-rule monitor: cyc==stb, and cyc low in the cycle after a response
  int gap_bad = 0;
  bit prev_end = 1'b0;
  always @(negedge clk) begin
    if (!rst_sys) begin
      if (wbm_cyc_o !== wbm_stb_o) gap_bad <= gap_bad + 1;
      if (prev_end && wbm_cyc_o) gap_bad <= gap_bad + 1;
    end
    prev_end <= wbm_ack_i | wbm_err_i;
  end

  // ---------------- Slave-side bus tasks ----------------
  task automatic wb_xfer(input logic we, input logic [1:0] word, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdat,
                         output logic ack, output logic err);
    bit done = 1'b0;
    @(posedge clk); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = {28'h0, word, 2'b00}; wbs_dat_i = dat; wbs_sel_i = sel;
    ack = 1'b0; err = 1'b0; rdat = '0;
    for (int i = 0; i < 8 && !done; i++) begin
      @(posedge clk); #1;
      if (wbs_ack_o || wbs_err_o) begin
        done = 1'b1; ack = wbs_ack_o; err = wbs_err_o; rdat = wbs_dat_o;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL wb_timeout: no response for word %0d", word);
    end
  endtask

  task automatic wr(input logic [1:0] w, input logic [31:0] d, output logic [1:0] resp);
    logic [31:0] r; logic a, e;
    wb_xfer(1'b1, w, d, 4'hF, r, a, e);
    resp = {a, e};
  endtask

  task automatic rd(input logic [1:0] w, output logic [31:0] d);
    logic a, e;
    wb_xfer(1'b0, w, 32'h0, 4'hF, d, a, e);
  endtask

  function automatic int n_tx(input int b);
    int n = 0;
    for (int k = b; k < acc_log.size(); k++) if (acc_log[k].we && !acc_log[k].err) n++;
    return n;
  endfunction

  task automatic wait_tx(input int b, input int n);
    int t = 0;
    while (n_tx(b) < n && t < 4000) begin @(posedge clk); #1; t++; end
    repeat (30) @(posedge clk);
    #1;
    check("tx_count", n_tx(b), n);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- Register table ----------------
  typedef struct {
    logic        we;
    logic [1:0]  word;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;
  vec_t tv[12];

  logic [31:0] rv;
  logic [1:0]  rs;
  logic        a_v, e_v, got;
  int          base, k;
  logic [7:0]  mq[$];
  bit          movf;
  logic [7:0]  bq[$];

  initial begin
    rst_sys = 1'b1;
    wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    #1;
    check("rst_ctl_outs", {wbs_ack_o, wbs_err_o, wbs_rty_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, irq}, 0);
    check("rst_adr_dat", {wbm_adr_o, wbs_dat_o}, 0);
    cycles(3);
    @(negedge clk) rst_sys = 1'b0;

    // Register table, FIFO empty, responder on
    resp_en = 1'b1;
    tv[0]  = '{1'b0, W_STAT, 32'h0,        4'hF, 32'h0000_0001};
    tv[1]  = '{1'b0, W_RSVD, 32'h0,        4'hF, 32'h0};
    tv[2]  = '{1'b1, W_RSVD, 32'hFFFF_FFFF, 4'hF, 32'h0};
    tv[3]  = '{1'b0, W_RSVD, 32'h0,        4'hF, 32'h0};
    tv[4]  = '{1'b0, W_CTRL, 32'h0,        4'hF, 32'h0};
    tv[5]  = '{1'b1, W_CTRL, 32'h2,        4'hF, 32'h0};
    tv[6]  = '{1'b0, W_CTRL, 32'h0,        4'hF, 32'h0000_0002};
    tv[7]  = '{1'b1, W_CTRL, 32'h1,        4'hF, 32'h0};
    tv[8]  = '{1'b0, W_CTRL, 32'h0,        4'hF, 32'h0};
    tv[9]  = '{1'b1, W_DATA, 32'hAB,       4'hE, 32'h0};
    tv[10] = '{1'b0, W_STAT, 32'h0,        4'hF, 32'h0000_0001};
    tv[11] = '{1'b0, W_DATA, 32'h0,        4'hF, 32'h0};
    base = acc_log.size();
    for (int i = 0; i < 12; i++) begin
      wb_xfer(tv[i].we, tv[i].word, tv[i].dat, tv[i].sel, rv, a_v, e_v);
      check($sformatf("tbl_resp[%0d]", i), {a_v, e_v}, 2'b10);
      if (!tv[i].we) check($sformatf("tbl_rdata[%0d]", i), rv, tv[i].exp);
    end
    cycles(10);
    check("tbl_no_master_traffic", acc_log.size() - base, 0);

    // Single byte: one LSR poll, one THR write; cyc follows the push by one edge
    lsr_busy = 0;
    base = acc_log.size();
    wr(W_DATA, 32'h41, rs);
    check("push_cyc_same_cycle", wbm_cyc_o, 1'b0);
    cycles(1);
    check("push_cyc_next_cycle", wbm_cyc_o, 1'b1);
    wait_tx(base, 1);
    check("b41_nacc", acc_log.size() - base, 2);
    check("b41_lsr", {acc_log[base].we, acc_log[base].adr, acc_log[base].sel}, {1'b0, UB + 32'd5, 4'b0100});
    check("b41_thr", {acc_log[base+1].we, acc_log[base+1].adr, acc_log[base+1].sel, acc_log[base+1].dat},
          {1'b1, UB, 4'b1000, 32'h4100_0000});
    rd(W_STAT, rv);
    check("b41_status", rv, 32'h0000_0001);

    // Busy UART: three polls see THRE clear, fourth sees it set
    lsr_busy = 3;
    base = acc_log.size();
    wr(W_DATA, 32'h5A, rs);
    wait_tx(base, 1);
    check("busy_nacc", acc_log.size() - base, 5);
    for (int i = 0; i < 4; i++)
      check($sformatf("busy_poll[%0d]", i), {acc_log[base+i].we, acc_log[base+i].adr, acc_log[base+i].dat},
            {1'b0, UB + 32'd5, (i == 3) ? 32'h0020_0000 : 32'h0});
    check("busy_thr", {acc_log[base+4].we, acc_log[base+4].dat}, {1'b1, 32'h5A00_0000});
    lsr_busy = 0;

    // Overflow with the UART stalled, then flush under an outstanding poll
    resp_en = 1'b0;
    base = acc_log.size();
    for (int i = 0; i < 16; i++) begin
      wr(W_DATA, 32'(i), rs);
      check($sformatf("fill_resp[%0d]", i), rs, 2'b10);
    end
    wr(W_DATA, 32'hEE, rs);
    check("ovf_resp", rs, OVF_ERR ? 2'b01 : 2'b10);
    rd(W_STAT, rv);
    check("ovf_status", rv, 32'h0000_1006);
    wr(W_CTRL, 32'h1, rs);
    rd(W_STAT, rv);
    check("flush_status", rv, 32'h0000_0001);
    resp_en = 1'b1;
    cycles(20);
    check("flush_outstanding_only", acc_log.size() - base, 1);
    check("flush_outstanding_is_rd", acc_log[base].we, 1'b0);
    check("flush_cyc_idle", wbm_cyc_o, 1'b0);

    // Error on THR write: no pop, restart with an LSR poll, bytes still in order
    resp_en = 1'b0;
    base = acc_log.size();
    wr(W_DATA, 32'h11, rs);
    wr(W_DATA, 32'h22, rs);
    wr(W_DATA, 32'h33, rs);
    rd(W_STAT, rv);
    check("err_pre_status", rv, 32'h0000_0300);
    err_wr_index = wr_served;
    resp_en = 1'b1;
    wait_tx(base, 3);
    check("err_seq_rd", acc_log[base].we, 1'b0);
    check("err_seq_wr_err", {acc_log[base+1].we, acc_log[base+1].err, acc_log[base+1].dat},
          {2'b11, 32'h1100_0000});
    check("err_restart_rd", acc_log[base+2].we, 1'b0);
    bq.delete();
    for (int j = base; j < acc_log.size(); j++)
      if (acc_log[j].we && !acc_log[j].err) bq.push_back(acc_log[j].dat[31:24]);
    check("err_tx_order", {bq[0], bq[1], bq[2]}, 24'h112233);
    err_wr_index = -1;

    // Flush with IRQ_EN while bytes are queued
    resp_en = 1'b0;
    base = acc_log.size();
    for (int i = 0; i < 5; i++) wr(W_DATA, 32'hA0 + 32'(i), rs);
    wr(W_CTRL, 32'h3, rs);
    got = 1'b0;
    for (int i = 0; i < 2; i++) begin @(posedge clk); #1; if (irq) got = 1'b1; end
    check("flush_irq", got, 1'b1);
    rd(W_STAT, rv);
    check("flush5_status", rv, 32'h0000_0001);
    rd(W_CTRL, rv);
    check("flush5_ctrl", rv, 32'h0000_0002);
    resp_en = 1'b1;
    cycles(20);
    check("flush5_no_tx", n_tx(base), 0);
    wr(W_CTRL, 32'h0, rs);
    cycles(2);
    check("irq_off", irq, 1'b0);

    // Randomized rounds against a queue model
    for (int r = 0; r < 8; r++) begin
      resp_en = 1'b0;
      base = acc_log.size();
      mq.delete();
      movf = 1'b0;
      k = $urandom_range(0, 20);
      for (int i = 0; i < k; i++) begin
        logic [7:0] d; logic [3:0] s; bit full_now;
        d = 8'($urandom);
        s = 4'($urandom);
        full_now = (mq.size() == 16);
        wb_xfer(1'b1, W_DATA, {24'($urandom), d}, s, rv, a_v, e_v);
        if (s[0]) begin
          if (!full_now) mq.push_back(d);
          else movf = 1'b1;
        end
        check("rnd_resp", {a_v, e_v}, (OVF_ERR && s[0] && full_now) ? 2'b01 : 2'b10);
      end
      rd(W_STAT, rv);
      check("rnd_status_fill", rv, {16'h0, 8'(mq.size()), 5'h0, movf, mq.size() == 16, mq.size() == 0});
      lsr_busy = $urandom_range(0, 2);
      resp_en = 1'b1;
      wait_tx(base, mq.size());
      k = 0;
      for (int j = base; j < acc_log.size(); j++)
        if (acc_log[j].we && !acc_log[j].err && k < mq.size()) begin
          check("rnd_tx_byte", acc_log[j].dat, {mq[k], 24'h0});
          k++;
        end
      rd(W_STAT, rv);
      check("rnd_status_drained", rv, {29'h0, movf, 2'b01});
      wr(W_CTRL, 32'h1, rs);
    end
    lsr_busy = 0;

    // Reset in the middle of an LSR poll
    resp_en = 1'b0;
    wr(W_DATA, 32'h77, rs);
    k = 0;
    while (!wbm_cyc_o && k < 10) begin @(posedge clk); #1; k++; end
    check("rst_mid_cyc_was_high", wbm_cyc_o, 1'b1);
    @(posedge clk); #2;
    rst_sys = 1'b1;
    #1;
    check("rst_mid_cyc_drop", {wbm_cyc_o, wbm_stb_o, wbm_adr_o}, 0);
    cycles(2);
    @(negedge clk) rst_sys = 1'b0;
    base = acc_log.size();
    rd(W_STAT, rv);
    check("rst_mid_status", rv, 32'h0000_0001);
    resp_en = 1'b1;
    cycles(10);
    check("rst_mid_no_traffic", acc_log.size() - base, 0);

    check("bus_rules", gap_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_uart_tx_feeder.md
WB_UART_TX_FEEDER -- requirements
Module: wb_uart_tx_feeder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, byte entries; must be a power of two in the range 2..128.
REQ-002 SHALL have parameter UART_BASE, default 32'h0, base address of the downstream 16550 register file.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 rst_sys  input  1  reset, asynchronous, active-high.
REQ-005 wbs_adr_i/dat_i/sel_i/cyc_i/stb_i/we_i  input  32/32/4/1/1/1  Wishbone B3 slave request (bus side).
REQ-006 wbs_ack_o/err_o/rty_o/dat_o  output  1/1/1/32  slave response; rty_o SHALL be tied 0.
REQ-007 wbm_adr_o/dat_o/sel_o/cyc_o/stb_o/we_o  output  32/32/4/1/1/1  master request to uart_top.
REQ-008 wbm_ack_i/err_i/dat_i  input  1/1/32  master response from uart_top.
REQ-009 irq  output  1  level interrupt to the PIC.

Function
REQ-010 Slave decode SHALL use wbs_adr_i[3:2]: 0 DATA (W), 1 STATUS (R), 2 CTRL (R/W), 3 reserved (reads 0, writes ignored, acked).
REQ-011 wbs_ack_o SHALL be a registered one-cycle pulse the cycle after cyc_i&stb_i is seen with ack low; a held request SHALL be acked every second cycle.
REQ-012 DATA write with sel_i[0]=1 SHALL push dat_i[7:0]; with sel_i[0]=0 it SHALL be acked with no push.
REQ-013 STATUS read SHALL return [15:8] count, [2] ovf (sticky), [1] full, [0] empty; all other bits 0.
REQ-014 CTRL bit0 FLUSH SHALL be write-1, self-clearing, and read 0; CTRL bit1 IRQ_EN SHALL be read/write with reset value 0.
REQ-015 full SHALL be count==FIFO_DEPTH on the registered count; a push while full SHALL be rejected even if a pop occurs in the same cycle.
REQ-016 A simultaneous push and pop while neither full nor empty SHALL both take effect, leaving count unchanged.
REQ-017 Master FSM SHALL have states IDLE, RD_LSR and WR_THR:
- IDLE -> RD_LSR when the FIFO is not empty.
- RD_LSR: adr=UART_BASE+5, we=0, sel=4'b0100.
- On ack in RD_LSR, THRE=wbm_dat_i[21]: 1 -> WR_THR; 0 -> repeat RD_LSR.
- WR_THR: adr=UART_BASE+0, we=1, sel=4'b1000, dat={head,24'h0}.
- On ack in WR_THR: pop, then -> IDLE.
REQ-018 wbm_cyc_o and wbm_stb_o SHALL be equal, held until ack_i or err_i, with at least one cycle low between consecutive accesses.
REQ-019 wbm_err_i SHALL end the current access with no pop, followed by an idle cycle and a restart at RD_LSR.
REQ-020 FLUSH SHALL zero count and pointers and clear ovf; an outstanding master access SHALL complete without a pop, then the FSM -> IDLE.
REQ-021 irq SHALL be registered, IRQ_EN & empty.
REQ-022 After a push into an empty FIFO with the FSM in IDLE, wbm_cyc_o SHALL rise in the cycle after the push is registered.

Reset
REQ-023 rst_sys SHALL asynchronously force:
- FSM to IDLE;
- count, pointers, ovf and IRQ_EN to 0;
- all wbm_* outputs, wbs_ack_o, wbs_err_o, wbs_dat_o and irq to 0.
REQ-024 Reset during an access SHALL drop wbm_cyc_o immediately and discard FIFO contents.
REQ-025 No FSM transition SHALL occur before the first rising clk edge after rst_sys deasserts.

Configuration
REQ-026 With WB_UART_TX_FEEDER_OVF_ERR_EN defined, a DATA write to a full FIFO SHALL get a wbs_err_o pulse (no ack), drop the byte, and set ovf.
REQ-027 Without the macro, the same write SHALL be acked, the byte dropped and ovf set; wbs_err_o SHALL be tied 0.

Structure
REQ-028 Package wb_uart_tx_feeder_pkg SHALL hold:
- slave register offsets;
- UART offsets THR=0, LSR=5;
- LSR_THRE bit index 5;
- the FSM state enum.
REQ-029 Sub-module wb_uart_tx_fifo SHALL implement the 8-bit synchronous FIFO (push/pop/flush/count/full/empty); the top SHALL hold slave decode and the master FSM.

Verification
REQ-030 Write DATA=0x41, LSR reads 0x0020_0000 -> one RD_LSR, then WR_THR with dat 0x4100_0000, sel 4'b1000, adr UART_BASE; STATUS then reads 0x0000_0001.
REQ-031 LSR reads 0x0 three times then 0x0020_0000 -> four RD_LSR accesses separated by cyc-low cycles, then exactly one WR_THR.
REQ-032 Master ack withheld, 17 DATA writes with depth 16 -> 17th gets err (macro on) or ack (macro off); STATUS reads 0x0000_1006.
REQ-033 wbm_err_i on WR_THR with 3 bytes queued -> no pop, count stays 3, next access is RD_LSR.
REQ-034 Write CTRL=0x3 with 5 bytes queued -> count 0, irq high within 2 cycles, CTRL reads 0x0000_0002.
REQ-035 rst_sys asserted mid-RD_LSR -> wbm_cyc_o low the same cycle; STATUS reads 0x0000_0001 after release.
